// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: passes low addresses through to the dmem
// syncram and decodes a small MMIO window (TX FIFO, cycle timer, scratch).
module dmem_mmio_responder #(
  parameter logic [11:0] MMIO_BASE  = 12'hFF0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam logic [FIFO_AW:0] CountFull = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        timer_q, timer_d;
  logic [31:0]        scratch_q, scratch_d;
  logic               sel_q;
  logic [31:0]        rdata_q, rdata_d;

  logic        is_mmio;
  logic [11:0] offset;
  logic        full, empty;
  logic        push, pop, do_push;
  logic [31:0] status;

  assign is_mmio  = (address_dmem >= MMIO_BASE);
  assign offset   = address_dmem - MMIO_BASE;
  assign mem_wren = wren & ~is_mmio;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr_q];

  assign push    = wren & is_mmio & (offset == 12'd0);
  assign pop     = tx_valid & tx_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push & (~full | pop);

  assign q_dmem = sel_q ? rdata_q : mem_q;

  // Next-state for FIFO bookkeeping, overflow, timer and scratch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    timer_d    = timer_q + 32'd1;
    scratch_d  = scratch_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;

    if (wren && is_mmio) begin
      if (offset == 12'd1 && data[10]) overflow_d = 1'b0;
      if (offset == 12'd2)             timer_d    = data;
      if (offset == 12'd3)             scratch_d  = data;
    end
    // A fresh overflow wins over a clear in the same cycle.
    if (push && full && !pop) overflow_d = 1'b1;
  end

  // MMIO read mux on pre-edge state.
  always_comb begin
    status             = '0;
    status[FIFO_AW:0]  = count_q;
    status[8]          = empty;
    status[9]          = full;
    status[10]         = overflow_q;
    rdata_d            = '0;
    if (is_mmio) begin
      case (offset)
        12'd1:   rdata_d = status;
        12'd2:   rdata_d = timer_q;
        12'd3:   rdata_d = scratch_q;
        default: rdata_d = '0;
      endcase
    end
  end

  // Control/state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timer_q    <= '0;
      scratch_q  <= '0;
      sel_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timer_q    <= timer_d;
      scratch_q  <= scratch_d;
      sel_q      <= is_mmio;
      rdata_q    <= rdata_d;
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clock) begin
    if (reset && do_push) fifo_mem[wr_ptr_q] <= data[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a behavioural dmem syncram.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ram [4096];
  logic [11:0] ram_addr_q;

  always #5 clock = ~clock;

  // Syncram model: registered address, one-cycle read latency.
  always_ff @(posedge clock) begin
    if (mem_wren) ram[address_dmem] <= data;
    ram_addr_q <= address_dmem;
  end
  assign mem_q = ram[ram_addr_q];

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    cyc();
    wren         = 1'b0;
    address_dmem = 12'h000;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    address_dmem = a;
    wren         = 1'b0;
    cyc();
    v            = q_dmem;
    address_dmem = 12'h000;
  endtask

  logic [31:0] v;
  logic [7:0]  drain_exp [8];

  initial begin
    reset        = 1'b0;
    address_dmem = 12'h000;
    data         = '0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    cyc();
    cyc();
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_mem_wren", {31'b0, mem_wren}, 32'h0);

    // Release reset while pointing at TIMER: first read sees 0, then 1.
    reset        = 1'b1;
    address_dmem = 12'hFF2;
    cyc();
    chk("timer_after_reset0", q_dmem, 32'h0);
    cyc();
    chk("timer_after_reset1", q_dmem, 32'h1);

    // Pass-through to dmem.
    address_dmem = 12'h010;
    data         = 32'hDEADBEEF;
    wren         = 1'b1;
    #1;
    chk("pt_mem_wren", {31'b0, mem_wren}, 32'h1);
    cyc();
    wren = 1'b0;
    cyc();
    chk("pt_read", q_dmem, 32'hDEADBEEF);
    address_dmem = 12'hFF3;
    data         = 32'h0;
    wren         = 1'b1;
    #1;
    chk("mmio_mem_wren", {31'b0, mem_wren}, 32'h0);
    cyc();
    wren = 1'b0;

    // FIFO ordering.
    wr(12'hFF0, 32'h41);
    wr(12'hFF0, 32'h42);
    wr(12'hFF0, 32'h43);
    rd(12'hFF1, v);
    chk("status_cnt3", v, 32'h0000_0003);
    chk("head_41", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    cyc();
    chk("head_42", {24'b0, tx_data}, 32'h42);
    cyc();
    chk("head_43", {24'b0, tx_data}, 32'h43);
    cyc();
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd(12'hFF1, v);
    chk("status_empty", v, 32'h0000_0100);

    // Overflow: ninth byte dropped.
    for (int i = 0; i < 9; i++) wr(12'hFF0, 32'h50 + i);
    rd(12'hFF1, v);
    chk("status_ovf", v, 32'h0000_0608);
    wr(12'hFF1, 32'h400);
    rd(12'hFF1, v);
    chk("status_ovf_clr", v, 32'h0000_0208);
    // Push while full with a pop in the same cycle.
    address_dmem = 12'hFF0;
    data         = 32'h60;
    wren         = 1'b1;
    tx_ready     = 1'b1;
    cyc();
    wren         = 1'b0;
    tx_ready     = 1'b0;
    address_dmem = 12'h000;
    rd(12'hFF1, v);
    chk("status_full_pushpop", v, 32'h0000_0208);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h51 + 8'(i);
    drain_exp[7] = 8'h60;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, drain_exp[i]});
      cyc();
    end
    chk("drain_done", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Timer load and wrap.
    wr(12'hFF2, 32'hFFFF_FFFE);
    address_dmem = 12'hFF2;
    cyc();
    chk("timer_load", q_dmem, 32'hFFFF_FFFE);
    cyc();
    chk("timer_max", q_dmem, 32'hFFFF_FFFF);
    cyc();
    chk("timer_wrap", q_dmem, 32'h0);

    // Scratch read-after-write and unmapped read.
    address_dmem = 12'hFF3;
    data         = 32'h1234_5678;
    wren         = 1'b1;
    cyc();
    chk("scratch_raw_old", q_dmem, 32'h0);
    wren = 1'b0;
    cyc();
    chk("scratch_new", q_dmem, 32'h1234_5678);
    wr(12'hFF9, 32'hFFFF_FFFF);
    rd(12'hFF9, v);
    chk("unmapped", v, 32'h0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) wr(12'hFF0, 32'h70 + i);
    tx_ready = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    rd(12'hFF1, v);
    chk("rst_status", v, 32'h0000_0100);
    rd(12'hFF2, v);
    chk("rst_timer", v, 32'h1);
    rd(12'hFF3, v);
    chk("rst_scratch", v, 32'h0);
    tx_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
